// File: rtl/sccb_pkg.sv
// Shared constants and state encoding for the SCCB register responder.
// The default device address and its derived write/read bytes live here.
package sccb_pkg;

    localparam logic [6:0] DEFAULT_DEV_ADDR = 7'h21;
    localparam int         REG_DEPTH        = 256;

    // Device byte on the wire: 7-bit address followed by the R/W bit.
    function automatic logic [7:0] dev_byte(input logic [6:0] addr, input logic rd);
        return {addr, rd};
    endfunction

    localparam logic [7:0] WR_BYTE = dev_byte(DEFAULT_DEV_ADDR, 1'b0);
    localparam logic [7:0] RD_BYTE = dev_byte(DEFAULT_DEV_ADDR, 1'b1);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DEV,
        ST_ACK_DEV,
        ST_SUB,
        ST_ACK_SUB,
        ST_WDATA,
        ST_ACK_W,
        ST_RDATA,
        ST_MACK,
        ST_IGNORE
    } state_e;

endpackage

// File: rtl/sccb_line_filter.sv
// Two-flop synchronizer plus FILTER-deep glitch filter for one bus line.
// Emits the filtered level and one-cycle rise/fall pulses aligned to it.
module sccb_line_filter #(
    parameter int FILTER = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic line_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CW = $clog2(FILTER + 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          rise_q, fall_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // Level only moves after FILTER consecutive samples disagree with it.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(FILTER - 1)) begin
                level_d = sync2_q;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    // Synchronizer, filter state and edge pulses; bus idles high.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= line_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            rise_q  <= level_d & ~level_q;
            fall_q  <= ~level_d & level_q;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/sccb_reg_responder.sv
// SCCB/I2C target: decodes device/sub-address/data writes and reads,
// stores bytes in a 256x8 register file and drives SDA for ACK and read data.
module sccb_reg_responder
    import sccb_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = DEFAULT_DEV_ADDR,
    parameter int         FILTER   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic       wr_stb,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy,
    input  logic [7:0] dbg_addr,
    output logic [7:0] dbg_data
);

    localparam logic [7:0] DEV_WR = dev_byte(DEV_ADDR, 1'b0);
    localparam logic [7:0] DEV_RD = dev_byte(DEV_ADDR, 1'b1);

    logic scl_lvl_s, scl_rise_s, scl_fall_s;
    logic sda_lvl_s, sda_rise_s, sda_fall_s;
    logic start_s, stop_s;

    state_e     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       byte_done_q, byte_done_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] sub_addr_q, sub_addr_d;
    logic       rw_q, rw_d;
    logic       mack_q, mack_d;
    logic       sda_oe_q, sda_oe_d;
    logic       busy_q, busy_d;
    logic       wr_stb_q, wr_stb_d;
    logic [7:0] wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic       mem_we_s;
    logic [7:0] rd_byte_s;
    logic [7:0] mem_q [REG_DEPTH];

    sccb_line_filter #(.FILTER(FILTER)) u_scl_filt (
        .clk    (clk),
        .rst    (rst),
        .line_i (scl_i),
        .level_o(scl_lvl_s),
        .rise_o (scl_rise_s),
        .fall_o (scl_fall_s)
    );

    sccb_line_filter #(.FILTER(FILTER)) u_sda_filt (
        .clk    (clk),
        .rst    (rst),
        .line_i (sda_i),
        .level_o(sda_lvl_s),
        .rise_o (sda_rise_s),
        .fall_o (sda_fall_s)
    );

    assign start_s   = sda_fall_s & scl_lvl_s;
    assign stop_s    = sda_rise_s & scl_lvl_s;
    assign rd_byte_s = mem_q[sub_addr_q];

    // Bus protocol FSM: shifting, ACK generation, read data and write strobes.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        byte_done_d = byte_done_q;
        shift_d     = shift_q;
        sub_addr_d  = sub_addr_q;
        rw_d        = rw_q;
        mack_d      = mack_q;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        wr_stb_d    = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        mem_we_s    = 1'b0;

        if (stop_s) begin
            state_d     = ST_IDLE;
            sda_oe_d    = 1'b0;
            busy_d      = 1'b0;
            bit_cnt_d   = 3'd0;
            byte_done_d = 1'b0;
        end else if (start_s) begin
            state_d     = ST_DEV;
            sda_oe_d    = 1'b0;
            busy_d      = 1'b1;
            bit_cnt_d   = 3'd0;
            byte_done_d = 1'b0;
        end else begin
            case (state_q)
                ST_DEV, ST_SUB, ST_WDATA: begin
                    if (scl_rise_s) begin
                        shift_d     = {shift_q[6:0], sda_lvl_s};
                        bit_cnt_d   = bit_cnt_q + 3'd1;
                        byte_done_d = (bit_cnt_q == 3'd7);
                    end else if (scl_fall_s && byte_done_q) begin
                        byte_done_d = 1'b0;
                        sda_oe_d    = 1'b1;
                        case (state_q)
                            ST_DEV: begin
                                if (shift_q == DEV_WR) begin
                                    state_d = ST_ACK_DEV;
                                    rw_d    = 1'b0;
                                end else if (shift_q == DEV_RD) begin
                                    state_d = ST_ACK_DEV;
                                    rw_d    = 1'b1;
                                end else begin
                                    state_d  = ST_IGNORE;
                                    sda_oe_d = 1'b0;
                                end
                            end
                            ST_SUB:   state_d = ST_ACK_SUB;
                            ST_WDATA: begin
                                state_d    = ST_ACK_W;
                                mem_we_s   = 1'b1;
                                wr_stb_d   = 1'b1;
                                wr_addr_d  = sub_addr_q;
                                wr_data_d  = shift_q;
                                sub_addr_d = sub_addr_q + 8'd1;
                            end
                            default: begin
                                state_d  = ST_IGNORE;
                                sda_oe_d = 1'b0;
                            end
                        endcase
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_ACK_DEV: begin
                    if (scl_fall_s) begin
                        bit_cnt_d = 3'd0;
                        if (rw_q) begin
                            state_d  = ST_RDATA;
                            sda_oe_d = ~rd_byte_s[7];
                        end else begin
                            state_d  = ST_SUB;
                            sda_oe_d = 1'b0;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_ACK_SUB: begin
                    if (scl_fall_s) begin
                        sub_addr_d = shift_q;
                        sda_oe_d   = 1'b0;
                        bit_cnt_d  = 3'd0;
                        state_d    = ST_WDATA;
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_ACK_W: begin
                    if (scl_fall_s) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 3'd0;
                        state_d   = ST_WDATA;
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_RDATA: begin
                    if (scl_rise_s) begin
                        bit_cnt_d   = bit_cnt_q + 3'd1;
                        byte_done_d = (bit_cnt_q == 3'd7);
                    end else if (scl_fall_s) begin
                        if (byte_done_q) begin
                            byte_done_d = 1'b0;
                            sda_oe_d    = 1'b0;
                            state_d     = ST_MACK;
                        end else begin
                            sda_oe_d = ~rd_byte_s[3'd7 - bit_cnt_q];
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_MACK: begin
                    if (scl_rise_s) begin
                        mack_d     = ~sda_lvl_s;
                        sub_addr_d = sub_addr_q + 8'd1;
                    end else if (scl_fall_s) begin
                        if (mack_q) begin
                            state_d   = ST_RDATA;
                            bit_cnt_d = 3'd0;
                            sda_oe_d  = ~rd_byte_s[7];
                        end else begin
                            state_d  = ST_IGNORE;
                            sda_oe_d = 1'b0;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_IDLE, ST_IGNORE: state_d = state_q;
                default: begin
                    state_d  = ST_IDLE;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    // Protocol state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            byte_done_q <= 1'b0;
            shift_q     <= 8'h00;
            sub_addr_q  <= 8'h00;
            rw_q        <= 1'b0;
            mack_q      <= 1'b0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            wr_stb_q    <= 1'b0;
            wr_addr_q   <= 8'h00;
            wr_data_q   <= 8'h00;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_done_q <= byte_done_d;
            shift_q     <= shift_d;
            sub_addr_q  <= sub_addr_d;
            rw_q        <= rw_d;
            mack_q      <= mack_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            wr_stb_q    <= wr_stb_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    // Register file; a same-cycle debug read sees the pre-write value.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (mem_we_s) begin
            mem_q[sub_addr_q] <= shift_q;
        end
    end

    assign sda_oe   = sda_oe_q;
    assign busy     = busy_q;
    assign wr_stb   = wr_stb_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign dbg_data = mem_q[dbg_addr];

endmodule

// File: tb/tb_sccb_reg_responder.sv
// Bench for sccb_reg_responder: bit-banged SCCB master, vector table,
// hand-written corner cases and random bursts checked against an array model.
module tb_sccb_reg_responder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_bus;
    logic       sda_oe, wr_stb, busy;
    logic [7:0] wr_addr, wr_data, dbg_addr, dbg_data;

    int         total = 0;
    int         bad = 0;
    int         wr_cnt = 0;
    logic [7:0] last_wa = 8'h00;
    logic [7:0] last_wd = 8'h00;
    logic       oe_seen = 1'b0;
    logic       busy_seen = 1'b0;
    logic [7:0] model [256];

    assign sda_bus = sda_m & ~sda_oe;

    sccb_reg_responder dut (
        .clk     (clk),
        .rst     (rst),
        .scl_i   (scl_m),
        .sda_i   (sda_bus),
        .sda_oe  (sda_oe),
        .wr_stb  (wr_stb),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .busy    (busy),
        .dbg_addr(dbg_addr),
        .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sda_oe) oe_seen = 1'b1;
        if (busy) busy_seen = 1'b1;
        if (wr_stb) begin
            wr_cnt  = wr_cnt + 1;
            last_wa = wr_addr;
            last_wd = wr_data;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: time limit reached, required finish before limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic peek(input logic [7:0] a, output logic [7:0] v);
        dbg_addr = a;
        #1;
        v = dbg_data;
    endtask

    task automatic bus_bit(input logic b, output logic s);
        sda_m = b;
        idle(8);
        scl_m = 1'b1;
        idle(8);
        s = sda_bus;
        idle(8);
        scl_m = 1'b0;
        idle(8);
    endtask

    task automatic bus_start();
        sda_m = 1'b1;
        idle(8);
        scl_m = 1'b1;
        idle(16);
        sda_m = 1'b0;
        idle(16);
        scl_m = 1'b0;
        idle(8);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0;
        idle(8);
        scl_m = 1'b1;
        idle(16);
        sda_m = 1'b1;
        idle(16);
    endtask

    task automatic write_byte(input logic [7:0] v, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bus_bit(v[i], s);
        bus_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic read_byte(input logic give_ack, output logic [7:0] v);
        logic s;
        v = 8'h00;
        for (int i = 0; i < 8; i++) begin
            bus_bit(1'b1, s);
            v = {v[6:0], s};
        end
        bus_bit(~give_ack, s);
    endtask

    // Full write transaction; counts data-phase NACKs and updates the model.
    task automatic write_burst(input logic [7:0] sub, input logic [7:0] d [$], output int nacks);
        logic ack;
        logic [7:0] a;
        nacks = 0;
        bus_start();
        write_byte(8'h42, ack); if (!ack) nacks++;
        write_byte(sub, ack);   if (!ack) nacks++;
        a = sub;
        foreach (d[i]) begin
            write_byte(d[i], ack);
            if (!ack) nacks++;
            model[a] = d[i];
            a = a + 8'd1;
        end
        bus_stop();
        idle(4);
    endtask

    // SCCB-style read: set sub-address, STOP, then START + read byte burst.
    task automatic read_burst(input logic [7:0] sub, input int n, output logic [7:0] got [$]);
        logic ack;
        logic [7:0] v;
        got = {};
        bus_start();
        write_byte(8'h42, ack);
        write_byte(sub, ack);
        bus_stop();
        bus_start();
        write_byte(8'h43, ack);
        check("rd_dev_ack", 32'(ack), 32'd1);
        for (int i = 0; i < n; i++) begin
            read_byte(i != n - 1, v);
            got.push_back(v);
        end
        bus_stop();
        idle(4);
    endtask

    typedef struct {
        logic [7:0] dev;
        logic [7:0] sub;
        logic [7:0] data;
        logic       exp_ack;
        logic [7:0] exp_reg;
    } vec_t;

    vec_t vecs [5];

    initial begin
        logic       a1, a2, a3, s;
        logic [7:0] v, sub;
        logic [7:0] q [$];
        logic [7:0] got [$];
        int         w0, nacks, n;

        vecs[0] = '{8'h42, 8'h12, 8'h14, 1'b1, 8'h14};
        vecs[1] = '{8'h60, 8'h12, 8'h55, 1'b0, 8'h14};
        vecs[2] = '{8'h42, 8'h00, 8'h5A, 1'b1, 8'h5A};
        vecs[3] = '{8'h44, 8'h00, 8'h11, 1'b0, 8'h5A};
        vecs[4] = '{8'h42, 8'h7F, 8'hC3, 1'b1, 8'hC3};
        for (int i = 0; i < 256; i++) model[i] = 8'h00;
        dbg_addr = 8'h00;

        idle(5);
        rst = 1'b0;
        idle(2);
        check("rst_sda_oe", 32'(sda_oe), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wr_stb", 32'(wr_stb), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        peek(8'hFF, v);
        check("rst_reg_ff", 32'(v), 32'd0);

        foreach (vecs[i]) begin
            oe_seen = 1'b0;
            w0 = wr_cnt;
            bus_start();
            write_byte(vecs[i].dev, a1);
            write_byte(vecs[i].sub, a2);
            write_byte(vecs[i].data, a3);
            bus_stop();
            idle(4);
            check("vec_dev_ack", 32'(a1), 32'(vecs[i].exp_ack));
            check("vec_oe_seen", 32'(oe_seen), 32'(vecs[i].exp_ack));
            check("vec_wr_cnt", 32'(wr_cnt - w0), 32'(vecs[i].exp_ack));
            check("vec_busy_end", 32'(busy), 32'd0);
            if (vecs[i].exp_ack) begin
                check("vec_sub_ack", 32'(a2), 32'd1);
                check("vec_data_ack", 32'(a3), 32'd1);
                check("vec_wr_addr", 32'(last_wa), 32'(vecs[i].sub));
                check("vec_wr_data", 32'(last_wd), 32'(vecs[i].data));
                model[vecs[i].sub] = vecs[i].data;
            end else begin
                check("vec_sub_nack", 32'(a2), 32'd0);
            end
            peek(vecs[i].sub, v);
            check("vec_reg", 32'(v), 32'(vecs[i].exp_reg));
        end

        // SCCB read of a freshly written address.
        q = {8'h04};
        write_burst(8'h3A, q, nacks);
        check("rd_setup_nacks", 32'(nacks), 32'd0);
        read_burst(8'h3A, 1, got);
        check("rd_value", 32'(got[0]), 32'h04);
        check("rd_busy_end", 32'(busy), 32'd0);
        check("rd_oe_end", 32'(sda_oe), 32'd0);

        // Burst write across the 0xFF -> 0x00 wrap, then read it back.
        w0 = wr_cnt;
        q = {8'hAA, 8'hBB};
        write_burst(8'hFF, q, nacks);
        check("wrap_nacks", 32'(nacks), 32'd0);
        check("wrap_wr_cnt", 32'(wr_cnt - w0), 32'd2);
        peek(8'hFF, v);
        check("wrap_reg_ff", 32'(v), 32'hAA);
        peek(8'h00, v);
        check("wrap_reg_00", 32'(v), 32'hBB);
        read_burst(8'hFF, 2, got);
        check("wrap_rd0", 32'(got[0]), 32'hAA);
        check("wrap_rd1", 32'(got[1]), 32'hBB);

        // Two-cycle SDA dip while SCL is high must not look like START.
        busy_seen = 1'b0;
        sda_m = 1'b0;
        idle(2);
        sda_m = 1'b1;
        idle(20);
        check("glitch_busy", 32'(busy_seen), 32'd0);

        // Reset in the middle of the data byte.
        w0 = wr_cnt;
        bus_start();
        write_byte(8'h42, a1);
        write_byte(8'h40, a2);
        for (int i = 0; i < 4; i++) bus_bit(1'b1, s);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mrst_sda_oe", 32'(sda_oe), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 256; i++) model[i] = 8'h00;
        bus_stop();
        idle(4);
        check("mrst_no_write", 32'(wr_cnt - w0), 32'd0);
        peek(8'h3A, v);
        check("mrst_cleared", 32'(v), 32'd0);
        q = {8'hD0};
        write_burst(8'h40, q, nacks);
        check("mrst_after_nacks", 32'(nacks), 32'd0);
        check("mrst_after_wa", 32'(last_wa), 32'h40);
        check("mrst_after_wd", 32'(last_wd), 32'hD0);
        peek(8'h40, v);
        check("mrst_after_reg", 32'(v), 32'hD0);

        // Random bursts against the array model.
        for (int t = 0; t < 12; t++) begin
            sub = 8'($urandom);
            n = $urandom_range(1, 3);
            if ($urandom_range(0, 1) == 1) begin
                q = {};
                for (int i = 0; i < n; i++) q.push_back(8'($urandom));
                w0 = wr_cnt;
                write_burst(sub, q, nacks);
                check("rnd_wr_nacks", 32'(nacks), 32'd0);
                check("rnd_wr_cnt", 32'(wr_cnt - w0), 32'(n));
            end else begin
                read_burst(sub, n, got);
                for (int i = 0; i < n; i++) begin
                    v = sub + 8'(i);
                    check("rnd_rd", 32'(got[i]), 32'(model[v]));
                end
            end
        end

        for (int i = 0; i < 256; i++) begin
            peek(8'(i), v);
            check("final_reg", 32'(v), 32'(model[i]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
